// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the schoolMIPS multiply/divide unit: operation codes
// handed to sm_muldiv and the R-type funct codes the decoder maps onto them.
package sm_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } mdOp_t;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    function automatic logic isSignedOp(input mdOp_t o);
        return (o == MD_MULT) || (o == MD_DIV);
    endfunction

    function automatic logic isDivOp(input mdOp_t o);
        return (o == MD_DIV) || (o == MD_DIVU);
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One iteration of the multiply/divide datapath: a shift-add multiply step or
// a restoring shift-subtract divide step over a {accHi, accLo} accumulator.
module sm_muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             isDiv,
    input  logic [WIDTH-1:0] accHi,
    input  logic [WIDTH-1:0] accLo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nextHi,
    output logic [WIDTH-1:0] nextLo
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
        shifted = {accHi, accLo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        if (isDiv) begin
            // Top bit of diff is the borrow: trial subtract failed, keep the shifted remainder.
            if (diff[WIDTH]) begin
                nextHi = shifted[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end else begin
                nextHi = diff[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end
        end else begin
            nextHi = sum[WIDTH:1];
            nextLo = {sum[0], accLo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; works on operand
// magnitudes one bit per cycle and applies the sign correction at the end.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             abort,
    input  logic             wrHi,
    input  logic             wrLo,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic             isDiv;
    logic             signA;
    logic             signB;
    logic             divZero;

    logic             reqDiv;
    logic             negA;
    logic             negB;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] resHi;
    logic [WIDTH-1:0] resLo;

    always_comb begin
        reqDiv = isDivOp(mdOp_t'(op));
        negA   = isSignedOp(mdOp_t'(op)) & srcA[WIDTH-1];
        negB   = isSignedOp(mdOp_t'(op)) & srcB[WIDTH-1];
        magA   = negA ? -srcA : srcA;
        magB   = negB ? -srcB : srcB;
    end

    sm_muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .isDiv   (isDiv),
        .accHi   (accHi),
        .accLo   (accLo),
        .operand (operand),
        .nextHi  (stepHi),
        .nextLo  (stepLo)
    );

    // Remainder follows the dividend sign, so a zero divisor hands srcA back in HI.
    always_comb begin
        product = {accHi, accLo};
        if (signA ^ signB) begin
            product = -product;
        end
        if (isDiv) begin
            resLo = (signA ^ signB) ? -accLo : accLo;
            resHi = signA ? -accHi : accHi;
            if (divZero) begin
                resLo = '1;
            end
        end else begin
            resHi = product[2*WIDTH-1:WIDTH];
            resLo = product[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            cnt     <= '0;
            operand <= '0;
            accHi   <= '0;
            accLo   <= '0;
            isDiv   <= 1'b0;
            signA   <= 1'b0;
            signB   <= 1'b0;
            divZero <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (wrHi) hi <= wrData;
                    if (wrLo) lo <= wrData;
                    if (start && !abort) begin
                        isDiv   <= reqDiv;
                        signA   <= negA;
                        signB   <= negB;
                        divZero <= reqDiv && (srcB == '0);
                        accHi   <= '0;
                        // Multiply shifts the multiplier out of accLo; divide shifts the dividend.
                        operand <= reqDiv ? magB : magA;
                        accLo   <= reqDiv ? magA : magB;
                        cnt     <= CNT_W'(WIDTH - 1);
                        state   <= StCalc;
                    end
                end
                StCalc: begin
                    if (abort) begin
                        state <= StIdle;
                    end else begin
                        accHi <= stepHi;
                        accLo <= stepLo;
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) state <= StFix;
                    end
                end
                StFix: begin
                    if (!abort) begin
                        hi   <= resHi;
                        lo   <= resLo;
                        done <= 1'b1;
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign busy = (state != StIdle);

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed and randomized bench for sm_muldiv against an arithmetic reference model.
module tb_sm_muldiv;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         wrHi = 1'b0;
    logic         wrLo = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic [W-1:0] wrData = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int failed = 0;

    sm_muldiv #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .abort  (abort),
        .wrHi   (wrHi),
        .wrLo   (wrLo),
        .wrData (wrData),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Returns {hi, lo} as the MIPS instruction defines them.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    task automatic waitResult(input string tag, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input int expLat);
        int          n;
        logic [63:0] want;
        n    = 0;
        want = model(o, a, b);
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(n), 64'(expLat));
        check({tag, " done"}, {63'd0, done}, 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, want[63:32]});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, want[31:0]});
    endtask

    initial begin
        logic [63:0] prev;

        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitResult("multu max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        @(negedge clk);
        check("done pulse width", {63'd0, done}, 64'd0);

        issue(2'd0, 32'hFFFF_FFFD, 32'd5);
        waitResult("mult neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 33);
        issue(2'd3, 32'd100, 32'd7);
        waitResult("divu back-to-back", 2'd3, 32'd100, 32'd7, 33);

        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        waitResult("div neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 33);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        waitResult("div overflow", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33);

        issue(2'd3, 32'h0000_1234, 32'd0);
        waitResult("divu by zero", 2'd3, 32'h0000_1234, 32'd0, 33);
        issue(2'd2, 32'd5, 32'd0);
        waitResult("div by zero", 2'd2, 32'd5, 32'd0, 33);

        // A start at cycle 10 of a running op is ignored.
        issue(2'd1, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        op    = 2'd0;
        srcA  = 32'd7;
        srcB  = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitResult("ignored start", 2'd1, 32'd3, 32'd4, 23);

        prev = model(2'd1, 32'd3, 32'd4);
        issue(2'd1, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("abort no done", {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        check("abort hi", {32'd0, hi}, {32'd0, prev[63:32]});
        check("abort lo", {32'd0, lo}, {32'd0, prev[31:0]});

        abort = 1'b1;
        start = 1'b1;
        op    = 2'd1;
        srcA  = 32'd2;
        srcB  = 32'd2;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort beats start", {63'd0, busy}, 64'd0);

        wrHi   = 1'b1;
        wrData = 32'hDEAD_BEEF;
        @(negedge clk);
        wrHi = 1'b0;
        check("wrHi idle", {32'd0, hi}, 64'hDEAD_BEEF);
        check("wrHi keeps lo", {32'd0, lo}, {32'd0, prev[31:0]});

        issue(2'd1, 32'd7, 32'd8);
        wrLo   = 1'b1;
        wrData = 32'h5555_5555;
        @(negedge clk);
        wrLo = 1'b0;
        check("wrLo while busy", {32'd0, lo}, {32'd0, prev[31:0]});
        waitResult("after wrLo", 2'd1, 32'd7, 32'd8, 32);

        // A write in the start cycle lands, then the result overwrites it.
        wrHi   = 1'b1;
        wrData = 32'hAAAA_5555;
        issue(2'd1, 32'd9, 32'd9);
        wrHi = 1'b0;
        check("write with start", {32'd0, hi}, 64'hAAAA_5555);
        waitResult("overwrite by result", 2'd1, 32'd9, 32'd9, 33);

        wrHi   = 1'b1;
        wrData = 32'hCAFE_F00D;
        issue(2'd2, 32'd1000, 32'd3);
        wrHi = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", {63'd0, busy}, 64'd0);
        check("async rst done", {63'd0, done}, 64'd0);
        check("async rst hi", {32'd0, hi}, 64'd0);
        check("async rst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 15);
                default: ;
            endcase
            issue(o, a, b);
            waitResult($sformatf("random %0d op%0d", i, o), o, a, b, 33);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
